// File: rtl/bt_pipe_pkg.sv
// Shared constants and flow-control helpers for the block-throttled pipe input buffer.
package bt_pipe_pkg;

   localparam int EP_DATA_W = 32;
   localparam int LAST_BIT  = 32;
   localparam int ENTRY_W   = 33;

   function automatic int fifo_capacity(input int block_words, input int depth_blocks);
      return block_words * depth_blocks;
   endfunction

   // True when a whole block still fits after stored words and the open block's reservation.
   function automatic logic block_room(input int capacity, input int used,
                                       input int reserved, input int block_words);
      return (used + reserved + block_words) <= capacity;
   endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module sdp_ram #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 1024,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              ti_clk,
   input  logic              ti_reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge ti_clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Only the read register is reset; it doubles as the presented output word.
   always_ff @(posedge ti_clk) begin
      if (ti_reset)  rdata <= '0;
      else if (re)   rdata <= mem[raddr];
   end

endmodule

// File: rtl/bt_pipe_in_buffer.sv
// Block-throttled pipe consumer: block-sized FIFO with ep_ready flow control and a
// first-word-fall-through valid/ready output carrying a per-block last marker.
module bt_pipe_in_buffer
   import bt_pipe_pkg::*;
#(
   parameter int BLOCK_WORDS  = 256,
   parameter int DEPTH_BLOCKS = 4,
   localparam int AW = $clog2(BLOCK_WORDS * DEPTH_BLOCKS)
) (
   input  logic                 ti_clk,
   input  logic                 ti_reset,
   input  logic                 ep_write,
   input  logic                 ep_blockstrobe,
   input  logic [EP_DATA_W-1:0] ep_dataout,
   output logic                 ep_ready,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [EP_DATA_W-1:0] m_data,
   output logic                 m_last,
   output logic [AW:0]          level,
   output logic                 overflow,
   output logic                 proto_err
);

   localparam int CAP = fifo_capacity(BLOCK_WORDS, DEPTH_BLOCKS);
   localparam int WCW = $clog2(BLOCK_WORDS);

   typedef logic [AW:0]  ptr_t;
   typedef logic [WCW-1:0] wcnt_t;
   typedef logic [WCW:0]   rem_t;

   ptr_t  wr_ptr, rd_ptr, level_nx;
   wcnt_t wcnt, wcnt_nx;
   rem_t  remaining, rem_nx;
   logic  full, push, pop, fetch, wr_last, ready_nx;
   logic [ENTRY_W-1:0] rd_entry;

   always_comb begin
      full     = (level == ptr_t'(CAP));
      push     = ep_write && !full;
      pop      = m_valid && m_ready;
      // The RAM read register is the output stage, so fetch whenever it is free or being drained.
      fetch    = (wr_ptr != rd_ptr) && (!m_valid || m_ready);
      level_nx = level + ptr_t'(push) - ptr_t'(pop);
      wcnt_nx  = wcnt;
      rem_nx   = remaining;
      if (ep_blockstrobe) begin
         wcnt_nx = '0;
         rem_nx  = rem_t'(BLOCK_WORDS);
      end
      wr_last = (wcnt_nx == wcnt_t'(BLOCK_WORDS - 1));
      if (ep_write) begin
         wcnt_nx = wcnt_nx + wcnt_t'(1);
         if (rem_nx != '0) rem_nx = rem_nx - rem_t'(1);
      end
      ready_nx = block_room(CAP, 32'(level_nx), 32'(rem_nx), BLOCK_WORDS);
   end

   always_ff @(posedge ti_clk) begin
      if (ti_reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         wcnt      <= '0;
         remaining <= '0;
         m_valid   <= 1'b0;
         ep_ready  <= 1'b0;
         overflow  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + ptr_t'(1);
         if (fetch) rd_ptr <= rd_ptr + ptr_t'(1);
         level     <= level_nx;
         wcnt      <= wcnt_nx;
         remaining <= rem_nx;
         m_valid   <= fetch || (m_valid && !m_ready);
         ep_ready  <= ready_nx;
         if (ep_write && full)                    overflow  <= 1'b1;
         if (ep_blockstrobe && remaining != '0)   proto_err <= 1'b1;
      end
   end

   sdp_ram #(
      .WIDTH (ENTRY_W),
      .DEPTH (CAP)
   ) u_ram (
      .ti_clk   (ti_clk),
      .ti_reset (ti_reset),
      .we       (push),
      .waddr    (wr_ptr[AW-1:0]),
      .wdata    ({wr_last, ep_dataout}),
      .re       (fetch),
      .raddr    (rd_ptr[AW-1:0]),
      .rdata    (rd_entry)
   );

   assign m_data = rd_entry[EP_DATA_W-1:0];
   assign m_last = rd_entry[LAST_BIT];

endmodule

// File: doc/bt_pipe_in_buffer.md
Name: bt_pipe_in_buffer

Overview:
- Consumer stage placed directly downstream of the block-throttled input pipe endpoint, in the ti_clk domain.
- Captures the 32-bit words written by the endpoint (ep_write / ep_dataout) into a block-sized FIFO.
- Drives the endpoint's ep_ready so the host starts a block only when a full block of space is guaranteed.
- Presents the data to user logic as a valid/ready stream with a per-block last marker.

Parameters:
- BLOCK_WORDS, 256: 32-bit words per host block; power of two, 16..1024.
- DEPTH_BLOCKS, 4: FIFO capacity in blocks; power of two, at least 2.
- AW, $clog2(BLOCK_WORDS*DEPTH_BLOCKS): derived RAM address width; not for override.

Ports:
- ti_clk  in  1  endpoint clock; all logic is on its rising edge
- ti_reset  in  1  synchronous, active-high reset
- ep_write  in  1  one-cycle qualifier for ep_dataout
- ep_blockstrobe  in  1  one-cycle pulse preceding each block of writes
- ep_dataout  in  32  write data from the endpoint
- ep_ready  out  1  registered; high = room for one more complete block
- m_valid  out  1  output word available
- m_ready  in  1  user consumes the word when m_valid & m_ready
- m_data  out  32  output word
- m_last  out  1  high with the final word of each block
- level  out  AW+1  words currently stored
- overflow  out  1  sticky: a write was dropped because the FIFO was full
- proto_err  out  1  sticky: ep_blockstrobe arrived mid-block

Behaviour:
- Reset (ti_reset high at an edge): ep_ready=0, m_valid=0, m_last=0, m_data=0, level=0, overflow=0, proto_err=0, pointers=0, wcnt=0, remaining=0.
- Reset mid-block discards all stored data. Sticky flags clear only on reset.
- Storage: BLOCK_WORDS*DEPTH_BLOCKS entries, each 33 bits ({last, data}). Pointers are AW+1 bits wide. Full when level==BLOCK_WORDS*DEPTH_BLOCKS.
- Block tracking on ep_blockstrobe:
  - wcnt <= 0 and remaining <= BLOCK_WORDS.
  - If remaining!=0 at the strobe, also set proto_err; the new block supersedes the old one.
- Write on ep_write:
  - If not full (judged on the start-of-cycle level), store {wcnt==BLOCK_WORDS-1, ep_dataout}.
  - Then wcnt <= wcnt+1, wrapping modulo BLOCK_WORDS, and remaining <= remaining-1, saturating at 0.
  - If full, drop the word and set overflow. A same-cycle pop does not rescue it.
  - Writes with no preceding strobe are accepted and use the running wcnt.
- ep_blockstrobe and ep_write in the same cycle: the strobe applies first; that write becomes word 0.
- ep_ready: registered from next-state values, high iff (capacity - level_next - remaining_next) >= BLOCK_WORDS.
  - Rises one cycle after reset deasserts.
  - Falls the cycle after the strobe of the block that consumes the last reserved space.
- Read side:
  - First-word-fall-through: a word written at edge N shows m_valid=1 after edge N+1 when the FIFO was empty.
  - Pop when m_valid & m_ready. The next word (if any) is presented the following cycle with no bubble.
  - m_data and m_last are held stable while m_valid & !m_ready.
- level counts stored words, including the presented word. Simultaneous push and pop leave level unchanged.
- RAM read latency is 1. The output stage is a one-entry register fed by a prefetch.

Decomposition:
- Package bt_pipe_pkg: EP_DATA_W=32, the 33-bit entry bit positions (LAST_BIT=32), and a helper function for the capacity and free-space computation.
- Sub-module sdp_ram: simple dual-port RAM (one write port, one registered read port), parameterised by width and depth, no reset on the array.
- The FIFO control, block tracker and output register live in bt_pipe_in_buffer.

Test Plan:
- Readiness after reset: reset 3 cycles, release -> ep_ready=1 one cycle later; level=0, m_valid=0.
- Single block: strobe, then 256 writes of 0..255 with m_ready=1 -> 256 outputs 0..255 in order; m_last only on 255; overflow=0.
- Back-pressure: m_ready=0, push blocks with BLOCK_WORDS=16, DEPTH_BLOCKS=4.
  - ep_ready drops after the 4th strobe.
  - level reaches 64 after 64 writes.
  - A forced 65th write sets overflow, and level stays 64.
- Release of reserved space: from 64 stored words, pop 16 -> ep_ready returns high the cycle after the 16th pop.
- Protocol error: strobe, 5 writes, strobe, 16 writes (BLOCK_WORDS=16) -> proto_err=1; the second block's word 15 carries m_last; the first 5 words have m_last=0.
- Mid-stream reset: reset during a block with level=20 -> next cycle level=0, m_valid=0, sticky flags clear, ep_ready returns 1 one cycle after release.
